// File: rtl/seq_hold_checker_pkg.sv
// Shared types and helpers for the repeating-count stream checker.
package seq_hold_checker_pkg;

   typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

   localparam int HOLD_DEF  = 5;
   localparam int RUN_W_DEF = $clog2(HOLD_DEF + 2);

   // Successor of v in the 0..maxval sequence; only meaningful for v <= maxval.
   function automatic logic [1:0] next_val(input logic [1:0] v, input logic [1:0] maxval);
      return (v == maxval) ? 2'd0 : v + 2'd1;
   endfunction

   // run_len must hold 0..HOLD+1
   function automatic int run_w(input int hold);
      return $clog2(hold + 2);
   endfunction

endpackage

// File: rtl/seq_hold_checker_sat_cnt.sv
// Saturating up-counter with increment enable and synchronous active-low reset.
module sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst)                 q <= '0;
      else if (en && q != '1)   q <= q + 1'b1;
   end

endmodule

// File: rtl/seq_hold_checker.sv
// Monitors a held 0..MAXVAL count stream: aligns on it, checks run lengths and steps, reports lock.
module seq_hold_checker
   import seq_hold_checker_pkg::*;
#(
   parameter int HOLD      = 5,
   parameter int MAXVAL    = 2,
   parameter int LOCK_RUNS = 3,
   parameter int CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    din,
   output logic          lock,
   output logic          err,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] period_cnt
);

   localparam int RLW = run_w(HOLD);
   localparam int GW  = (LOCK_RUNS < 2) ? 1 : $clog2(LOCK_RUNS + 1);
   localparam logic [RLW-1:0] HOLD_L  = RLW'(HOLD);
   localparam logic [GW-1:0]  LRUNS_L = GW'(LOCK_RUNS);
   localparam logic [1:0]     MAX_L   = 2'(MAXVAL);

   state_t         state, state_n;
   logic [1:0]     prev;
   logic [RLW-1:0] run_len, run_len_n;
   logic [GW-1:0]  good_runs, good_n;
   logic           trans, step_ok, viol, per_inc;

   always_comb begin
      state_n   = state;
      run_len_n = run_len;
      good_n    = good_runs;
      viol      = 1'b0;
      per_inc   = 1'b0;
      trans     = (din != prev);
      // a value above MAXVAL has no legal successor
      step_ok   = (prev <= MAX_L) && (din == next_val(prev, MAX_L));
      case (state)
         ACQUIRE: begin
            if (trans && step_ok) begin
               state_n   = TRACK;
               run_len_n = RLW'(1);
               good_n    = '0;
            end
         end
         TRACK, LOCKED: begin
            if (!trans) begin
               if (run_len < HOLD_L) run_len_n = run_len + 1'b1;
               else                  viol      = 1'b1;
            end else if (run_len == HOLD_L && step_ok) begin
               run_len_n = RLW'(1);
               per_inc   = (state == LOCKED) && (prev == MAX_L);
               if (good_runs < LRUNS_L) good_n = good_runs + 1'b1;
               if (good_n == LRUNS_L)   state_n = LOCKED;
            end else begin
               viol = 1'b1;
            end
         end
         default: state_n = ACQUIRE;
      endcase
      if (viol) begin
         state_n = ACQUIRE;
         good_n  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ACQUIRE;
         prev       <= 2'd0;
         run_len    <= '0;
         good_runs  <= '0;
         lock       <= 1'b0;
         err        <= 1'b0;
         period_cnt <= '0;
      end else begin
         state      <= state_n;
         prev       <= din;
         run_len    <= run_len_n;
         good_runs  <= good_n;
         lock       <= (state_n == LOCKED);
         err        <= viol;
         if (per_inc) period_cnt <= period_cnt + 1'b1;
      end
   end

   sat_cnt #(.W(CW)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .en  (viol),
      .q   (err_cnt)
   );

endmodule

// File: tb/tb_seq_hold_checker.sv
// Directed bench for seq_hold_checker: default instance plus a CW=2 instance on the same stimulus.
module tb_seq_hold_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] din;
   logic       lock, err, lock2, err2;
   logic [7:0] err_cnt, period_cnt;
   logic [1:0] err_cnt2, period_cnt2;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;

   always #5 clk = ~clk;

   seq_hold_checker dut (
      .clk(clk), .rst(rst), .din(din),
      .lock(lock), .err(err), .err_cnt(err_cnt), .period_cnt(period_cnt)
   );

   seq_hold_checker #(.CW(2)) dut2 (
      .clk(clk), .rst(rst), .din(din),
      .lock(lock2), .err(err2), .err_cnt(err_cnt2), .period_cnt(period_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // present v for n cycles; outputs after each step reflect the value just sampled
   task automatic drive(input logic [1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         din = v;
         @(posedge clk);
         #1;
         if (err) err_seen++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      din = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // clean stream from reset: lock appears after the cycle-20 sample, period 1 after cycle 30
   task automatic clean_sched(input string pfx);
      err_seen = 0;
      drive(0, 5); drive(1, 5); drive(2, 5); drive(0, 5);
      chk({pfx, "_lock_pre"}, lock, 0);
      drive(1, 1);
      chk({pfx, "_lock_set"}, lock, 1);
      drive(1, 4); drive(2, 5);
      chk({pfx, "_period0"}, period_cnt, 0);
      drive(0, 1);
      chk({pfx, "_period1"}, period_cnt, 1);
      chk({pfx, "_no_err"}, err_seen, 0);
   endtask

   initial begin
      do_reset();
      chk("rst_lock", lock, 0);
      chk("rst_err", err, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_period", period_cnt, 0);

      // scenario 1: clean stream
      clean_sched("clean");

      // scenario 2: run of 1 held six cycles while locked
      drive(0, 4); drive(1, 5);
      chk("long_pre_err", err, 0);
      drive(1, 1);
      chk("long_err", err, 1);
      chk("long_lock", lock, 0);
      chk("long_errcnt", err_cnt, 1);
      drive(2, 1);
      chk("long_err_pulse", err, 0);
      drive(2, 4); drive(0, 5); drive(1, 5);
      chk("relock_pre", lock, 0);
      drive(2, 1);
      chk("relock", lock, 1);
      chk("relock_period", period_cnt, 1);

      // scenario 3: short run of 0, and the violating 0->1 edge must not reacquire
      drive(2, 4); drive(0, 4);
      chk("short_period", period_cnt, 2);
      drive(1, 1);
      chk("short_err", err, 1);
      chk("short_errcnt", err_cnt, 2);
      chk("short_lock", lock, 0);
      drive(1, 4); drive(2, 5); drive(0, 5); drive(1, 1);
      chk("no_reuse_lock", lock, 0);
      drive(1, 4); drive(2, 1);
      chk("no_reuse_relock", lock, 1);

      // scenario 4: skipped value, then din above MAXVAL
      drive(2, 4); drive(0, 5);
      chk("skip_period_pre", period_cnt, 3);
      drive(2, 1);
      chk("skip_err", err, 1);
      chk("skip_errcnt", err_cnt, 3);
      drive(0, 1);
      drive(0, 4); drive(3, 1);
      chk("over_err", err, 1);
      chk("over_errcnt", err_cnt, 4);
      chk("over_period", period_cnt, 3);

      // scenario 5: reset while locked, then the same schedule again
      drive(0, 5); drive(1, 5); drive(2, 5); drive(0, 5); drive(1, 1);
      chk("pre_rst_lock", lock, 1);
      do_reset();
      chk("mid_rst_lock", lock, 0);
      chk("mid_rst_errcnt", err_cnt, 0);
      chk("mid_rst_period", period_cnt, 0);
      clean_sched("reclean");

      // scenario 6: CW=2 saturation of err_cnt and wrap of period_cnt
      do_reset();
      drive(0, 5); drive(1, 5); drive(1, 1);
      chk("sat_err_0", err2, 1);
      chk("sat_cnt_0", err_cnt2, 1);
      begin
         logic [1:0] v;
         logic [1:0] exp_cnt;
         v = 2'd2;
         exp_cnt = 2'd1;
         for (int k = 0; k < 4; k++) begin
            drive(v, 6);
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            chk($sformatf("sat_err_%0d", k + 1), err2, 1);
            chk($sformatf("sat_cnt_%0d", k + 1), err_cnt2, exp_cnt);
            v = (v == 2'd2) ? 2'd0 : v + 2'd1;
         end
      end

      do_reset();
      drive(0, 5); drive(1, 5); drive(2, 5); drive(0, 5); drive(1, 5); drive(2, 5);
      chk("wrap_lock", lock2, 1);
      begin
         logic [1:0] exp_p;
         exp_p = 2'd0;
         for (int k = 0; k < 4; k++) begin
            drive(0, 1);
            exp_p = exp_p + 2'd1;
            chk($sformatf("wrap_period_%0d", k), period_cnt2, exp_p);
            drive(0, 4); drive(1, 5); drive(2, 5);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
